// File: rtl/band_normalizer.sv
// ============================================================================
//  Module   : band_normalizer
//  Purpose  : Scales each completed band of binner sums to 8-bit features and
//             streams them to the classifier feature memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module band_normalizer #(
    parameter int MULT  = 1198,
    parameter int SHIFT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0][31:0][15:0] r_data,
    input  logic [1:0][31:0][15:0] g_data,
    input  logic [1:0][31:0][15:0] b_data,
    input  logic [5:0]             row_i,
    input  logic                   pxl_idle_i,
    output logic                   feat_valid,
    input  logic                   feat_ready,
    output logic [11:0]            feat_addr,
    output logic [7:0]             feat_data,
    output logic                   busy_o,
    output logic                   band_done_o,
    output logic                   frame_done_o,
    output logic                   overrun_o
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_load = 2'd1;
    localparam logic [1:0]  c_st_mul  = 2'd2;
    localparam logic [1:0]  c_st_out  = 2'd3;
    localparam logic [27:0] c_mult    = 28'(MULT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [5:0]  r_row_prev;
    logic        r_idle_prev;
    logic [4:0]  r_band;
    logic [4:0]  r_bin;
    logic [1:0]  r_ch;
    logic        r_set;
    logic [15:0] r_operand;

    logic        w_event;
    logic        w_frame_start;
    logic        w_abort;
    logic        w_accept;
    logic        w_last;
    logic [15:0] w_operand_sel;
    logic [27:0] w_prod;
    logic [27:0] w_q;
    logic [7:0]  w_scaled;
    logic [11:0] w_addr;

    assign w_event       = (row_i != r_row_prev) && (row_i != 6'd0) && !pxl_idle_i;
    assign w_frame_start = r_idle_prev && !pxl_idle_i;
    assign w_abort       = (r_state != c_st_idle) && pxl_idle_i && !r_idle_prev;
    assign w_accept      = (r_state == c_st_out) && feat_valid && feat_ready;
    assign w_last        = (r_bin == 5'd31) && (r_ch == 2'd2);
    assign busy_o        = (r_state != c_st_idle);

    always_comb begin
        w_operand_sel = 16'd0;
        case (r_ch)
            2'd0:    w_operand_sel = r_data[r_set][r_bin];
            2'd1:    w_operand_sel = g_data[r_set][r_bin];
            2'd2:    w_operand_sel = b_data[r_set][r_bin];
            default: w_operand_sel = 16'd0;
        endcase
    end

    // Single multiply per feature; the reciprocal maps a full-scale sum to 255.
    assign w_prod   = 28'(r_operand) * c_mult;
    assign w_q      = w_prod >> SHIFT;
    assign w_scaled = (w_q > 28'd255) ? 8'd255 : w_q[7:0];
    assign w_addr   = 12'(r_band) * 12'd96 + 12'(r_bin) * 12'd3 + 12'(r_ch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_event) w_state_next = c_st_load;
            c_st_load: w_state_next = c_st_mul;
            c_st_mul:  w_state_next = c_st_out;
            c_st_out:  if (w_accept) w_state_next = w_last ? c_st_idle : c_st_load;
            default:   w_state_next = c_st_idle;
        endcase
        if (w_abort) w_state_next = c_st_idle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_prev  <= 6'd0;
            r_idle_prev <= 1'b0;
        end else begin
            r_row_prev  <= row_i;
            r_idle_prev <= pxl_idle_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_band       <= 5'd0;
            r_bin        <= 5'd0;
            r_ch         <= 2'd0;
            r_set        <= 1'b0;
            r_operand    <= 16'd0;
            feat_valid   <= 1'b0;
            feat_addr    <= 12'd0;
            feat_data    <= 8'd0;
            band_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            band_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            if (w_frame_start) overrun_o <= 1'b0;
            // A band arriving mid-operation is dropped, only flagged.
            if (w_event && (r_state != c_st_idle)) overrun_o <= 1'b1;

            if (w_abort) begin
                feat_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_event) begin
                            r_band <= 5'(row_i - 6'd1);
                            r_set  <= ~row_i[0];
                            r_bin  <= 5'd0;
                            r_ch   <= 2'd0;
                        end
                    end
                    c_st_load: begin
                        r_operand <= w_operand_sel;
                    end
                    c_st_mul: begin
                        feat_data  <= w_scaled;
                        feat_addr  <= w_addr;
                        feat_valid <= 1'b1;
                    end
                    c_st_out: begin
                        if (w_accept) begin
                            feat_valid <= 1'b0;
                            if (w_last) begin
                                band_done_o  <= 1'b1;
                                frame_done_o <= (r_band == 5'd31);
                            end else if (r_ch == 2'd2) begin
                                r_ch  <= 2'd0;
                                r_bin <= r_bin + 5'd1;
                            end else begin
                                r_ch <= r_ch + 2'd1;
                            end
                        end
                    end
                    default: begin
                        feat_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_band_normalizer.sv
// ============================================================================
//  Module   : tb_band_normalizer
//  Purpose  : Directed self-checking bench for band_normalizer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_band_normalizer;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0][31:0][15:0] r_data;
    logic [1:0][31:0][15:0] g_data;
    logic [1:0][31:0][15:0] b_data;
    logic [5:0]             row_i;
    logic                   pxl_idle_i;
    logic                   feat_valid;
    logic                   feat_ready;
    logic [11:0]            feat_addr;
    logic [7:0]             feat_data;
    logic                   busy_o;
    logic                   band_done_o;
    logic                   frame_done_o;
    logic                   overrun_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [11:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];
    int          bd_cnt = 0;
    int          bd_cyc = 0;
    int          fd_cnt = 0;
    int          fd_with_bd = 0;
    int          hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_addr = 12'd0;
    logic [7:0]  prev_data = 8'd0;

    band_normalizer #(.MULT(1198), .SHIFT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .r_data       (r_data),
        .g_data       (g_data),
        .b_data       (b_data),
        .row_i        (row_i),
        .pxl_idle_i   (pxl_idle_i),
        .feat_valid   (feat_valid),
        .feat_ready   (feat_ready),
        .feat_addr    (feat_addr),
        .feat_data    (feat_data),
        .busy_o       (busy_o),
        .band_done_o  (band_done_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !pxl_idle_i &&
                (feat_valid !== 1'b1 || feat_addr !== prev_addr || feat_data !== prev_data))
                hold_err <= hold_err + 1;
            if (feat_valid && feat_ready) begin
                wr_addr.push_back(feat_addr);
                wr_data.push_back(feat_data);
                wr_cyc.push_back(cyc);
            end
            if (band_done_o) begin
                bd_cnt <= bd_cnt + 1;
                bd_cyc <= cyc;
            end
            if (frame_done_o) begin
                fd_cnt <= fd_cnt + 1;
                if (band_done_o) fd_with_bd <= fd_with_bd + 1;
            end
            prev_stall <= feat_valid && !feat_ready;
            prev_addr  <= feat_addr;
            prev_data  <= feat_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        row_i      = 6'd0;
        pxl_idle_i = 1'b1;
        feat_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic start_frame;
        pxl_idle_i = 1'b1;
        tick(2);
        pxl_idle_i = 1'b0;
        tick(2);
    endtask

    task automatic fill_all(input logic [15:0] v0, input logic [15:0] v1);
        for (int i = 0; i < 32; i++) begin
            r_data[0][i] = v0; g_data[0][i] = v0; b_data[0][i] = v0;
            r_data[1][i] = v1; g_data[1][i] = v1; b_data[1][i] = v1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; row_i = 6'd0; pxl_idle_i = 1'b1; feat_ready = 1'b1;
        fill_all(16'd0, 16'd0);
        tick(2);
        total++; if (feat_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", feat_valid); end
        total++; if (feat_addr !== 12'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", feat_addr); end
        total++; if (feat_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", feat_data); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        total++; if ({band_done_o, frame_done_o, overrun_o} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%b exp=000", {band_done_o, frame_done_o, overrun_o}); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single_band;
        int wb, bb, n, nb, t0;
        do_reset();
        fill_all(16'd450, 16'd450);
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt;
        row_i = 6'd1; t0 = cyc;
        for (int i = 0; i < 500 && bd_cnt == bb; i++) tick(1);
        tick(5);
        n = wr_addr.size() - wb;
        total++; if (n != 96) begin bad++; $display("FAIL single_count got=%0d exp=96", n); end
        nb = 0;
        for (int i = 0; i < n; i++) if (wr_addr[wb+i] !== 12'(i) || wr_data[wb+i] !== 8'd8) nb++;
        total++; if (nb != 0) begin bad++; $display("FAIL single_addr_data bad_entries=%0d exp=0", nb); end
        total++; if (n > 0 && wr_cyc[wb] != t0 + 3) begin bad++;
            $display("FAIL single_first_write cycle=%0d exp=%0d", wr_cyc[wb], t0 + 3); end
        total++; if (bd_cnt - bb != 1) begin bad++; $display("FAIL single_band_done got=%0d exp=1", bd_cnt - bb); end
        total++; if (bd_cyc != t0 + 289) begin bad++; $display("FAIL single_done_time got=%0d exp=%0d", bd_cyc, t0 + 289); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL single_overrun got=%0b exp=0", overrun_o); end
    endtask

    task automatic test_scaling;
        int wb, bb, n;
        do_reset();
        fill_all(16'd0, 16'd450);
        r_data[0][0] = 16'd0;
        r_data[0][1] = 16'd7000;
        r_data[0][2] = 16'd13950;
        r_data[0][3] = 16'hFFFF;
        g_data[0][1] = 16'd900;
        b_data[0][2] = 16'd1000;
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt;
        row_i = 6'd1;
        for (int i = 0; i < 500 && bd_cnt == bb; i++) tick(1);
        tick(2);
        n = wr_addr.size() - wb;
        total++; if (n != 96) begin bad++; $display("FAIL scale_count got=%0d exp=96", n); end
        if (n == 96) begin
            total++; if (wr_data[wb+0] !== 8'd0)   begin bad++; $display("FAIL scale_r0 got=%0d exp=0",   wr_data[wb+0]); end
            total++; if (wr_data[wb+3] !== 8'd127) begin bad++; $display("FAIL scale_r1 got=%0d exp=127", wr_data[wb+3]); end
            total++; if (wr_data[wb+6] !== 8'd255) begin bad++; $display("FAIL scale_r2 got=%0d exp=255", wr_data[wb+6]); end
            total++; if (wr_data[wb+9] !== 8'd255) begin bad++; $display("FAIL scale_r3_sat got=%0d exp=255", wr_data[wb+9]); end
            total++; if (wr_data[wb+4] !== 8'd16)  begin bad++; $display("FAIL scale_g1 got=%0d exp=16",  wr_data[wb+4]); end
            total++; if (wr_data[wb+8] !== 8'd18)  begin bad++; $display("FAIL scale_b2 got=%0d exp=18",  wr_data[wb+8]); end
        end
    endtask

    task automatic test_backpressure;
        int wb, bb, hb, n, nb, v, q;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            r_data[0][i] = 16'(i * 400);
            g_data[0][i] = 16'(i * 400 + 100);
            b_data[0][i] = 16'(i * 400 + 200);
            r_data[1][i] = 16'hFFFF; g_data[1][i] = 16'hFFFF; b_data[1][i] = 16'hFFFF;
        end
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt; hb = hold_err;
        row_i = 6'd1;
        for (int i = 0; i < 3000 && bd_cnt == bb; i++) begin
            feat_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        feat_ready = 1'b1;
        tick(3);
        n = wr_addr.size() - wb;
        total++; if (n != 96) begin bad++; $display("FAIL bp_count got=%0d exp=96", n); end
        nb = 0;
        for (int i = 0; i < n; i++) begin
            v = (i / 3) * 400 + (i % 3) * 100;
            q = (v * 1198) >> 16;
            e = (q > 255) ? 8'd255 : 8'(q);
            if (wr_addr[wb+i] !== 12'(i) || wr_data[wb+i] !== e) nb++;
        end
        total++; if (nb != 0) begin bad++; $display("FAIL bp_sequence bad_entries=%0d exp=0", nb); end
        total++; if (hold_err != hb) begin bad++; $display("FAIL bp_hold violations=%0d exp=0", hold_err - hb); end
    endtask

    task automatic test_full_frame;
        int wb, bb, fb, cb, n, nb;
        logic [7:0] e;
        do_reset();
        fill_all(16'd450, 16'd13950);
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt; fb = fd_cnt; cb = fd_with_bd;
        for (int k = 1; k <= 32; k++) begin
            row_i = 6'(k);
            tick(1000);
        end
        n = wr_addr.size() - wb;
        total++; if (n != 3072) begin bad++; $display("FAIL frame_count got=%0d exp=3072", n); end
        nb = 0;
        for (int i = 0; i < n; i++) begin
            e = ((i / 96) % 2 == 0) ? 8'd8 : 8'd255;
            if (wr_addr[wb+i] !== 12'(i) || wr_data[wb+i] !== e) nb++;
        end
        total++; if (nb != 0) begin bad++; $display("FAIL frame_sequence bad_entries=%0d exp=0", nb); end
        total++; if (n == 3072 && wr_data[wb+3071] !== 8'd255) begin bad++;
            $display("FAIL frame_last_set got=%0d exp=255", wr_data[wb+3071]); end
        total++; if (bd_cnt - bb != 32) begin bad++; $display("FAIL frame_band_done got=%0d exp=32", bd_cnt - bb); end
        total++; if (fd_cnt - fb != 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt - fb); end
        total++; if (fd_with_bd - cb != 1) begin bad++; $display("FAIL frame_done_coincident got=%0d exp=1", fd_with_bd - cb); end
    endtask

    task automatic test_overrun;
        int wb, bb, n;
        do_reset();
        fill_all(16'd450, 16'd450);
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt;
        row_i = 6'd1;
        tick(50);
        row_i = 6'd2;
        tick(1);
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b exp=1", overrun_o); end
        tick(700);
        n = wr_addr.size() - wb;
        total++; if (n != 96) begin bad++; $display("FAIL ovr_writes got=%0d exp=96", n); end
        total++; if (n > 0 && wr_addr[wb+n-1] !== 12'd95) begin bad++;
            $display("FAIL ovr_last_addr got=%0d exp=95", wr_addr[wb+n-1]); end
        total++; if (bd_cnt - bb != 1) begin bad++; $display("FAIL ovr_band_done got=%0d exp=1", bd_cnt - bb); end
        pxl_idle_i = 1'b1;
        tick(2);
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun_o); end
        pxl_idle_i = 1'b0;
        tick(1);
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b exp=0", overrun_o); end
    endtask

    task automatic test_abort;
        int wb, bb, fb, n;
        do_reset();
        fill_all(16'd450, 16'd450);
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt; fb = fd_cnt;
        row_i = 6'd1;
        for (int i = 0; i < 500 && (wr_addr.size() - wb) < 40; i++) tick(1);
        total++; if (wr_addr.size() - wb != 40) begin bad++;
            $display("FAIL abort_reach40 got=%0d exp=40", wr_addr.size() - wb); end
        feat_ready = 1'b0;
        tick(2);
        total++; if (feat_valid !== 1'b1 || feat_addr !== 12'd40) begin bad++;
            $display("FAIL abort_stalled valid=%0b addr=%0d exp valid=1 addr=40", feat_valid, feat_addr); end
        pxl_idle_i = 1'b1;
        tick(1);
        total++; if (feat_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b exp=0", feat_valid); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy_o); end
        feat_ready = 1'b1;
        tick(400);
        n = wr_addr.size() - wb;
        total++; if (n != 40) begin bad++; $display("FAIL abort_writes got=%0d exp=40", n); end
        total++; if (bd_cnt != bb || fd_cnt != fb) begin bad++;
            $display("FAIL abort_no_done band=%0d frame=%0d exp=0", bd_cnt - bb, fd_cnt - fb); end
    endtask

    task automatic test_reset_mid;
        int wb, bb;
        do_reset();
        fill_all(16'd450, 16'd450);
        start_frame();
        wb = wr_addr.size(); bb = bd_cnt;
        row_i = 6'd1;
        for (int i = 0; i < 200 && (wr_addr.size() - wb) < 10; i++) tick(1);
        feat_ready = 1'b0;
        tick(3);
        total++; if (feat_valid !== 1'b1 || feat_addr !== 12'd10) begin bad++;
            $display("FAIL rstmid_pre valid=%0b addr=%0d exp valid=1 addr=10", feat_valid, feat_addr); end
        reset = 1'b1; row_i = 6'd0; pxl_idle_i = 1'b1;
        #2;
        total++; if ({feat_valid, busy_o, band_done_o, frame_done_o, overrun_o} !== 5'b0) begin bad++;
            $display("FAIL rstmid_flags got=%b exp=00000", {feat_valid, busy_o, band_done_o, frame_done_o, overrun_o}); end
        total++; if (feat_addr !== 12'd0 || feat_data !== 8'd0) begin bad++;
            $display("FAIL rstmid_bus addr=%0d data=%0d exp 0 0", feat_addr, feat_data); end
        tick(2);
        reset = 1'b0; feat_ready = 1'b1;
        tick(400);
        total++; if (wr_addr.size() - wb != 10 || bd_cnt != bb || busy_o !== 1'b0) begin bad++;
            $display("FAIL rstmid_no_resume writes=%0d band_done=%0d busy=%0b exp 10 0 0",
                     wr_addr.size() - wb, bd_cnt - bb, busy_o); end
    endtask

    initial begin
        test_reset();
        test_single_band();
        test_scaling();
        test_backpressure();
        test_full_frame();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
